// File: rtl/regfile_writeback_if.sv
// Writeback bundle: load/ALU request channels, register-file write port,
// bypass lookup and queue status.
interface regfile_writeback_if #(
  parameter int DATA_W = 64
);
  logic              mem_valid;
  logic              mem_ready;
  logic [4:0]        mem_reg;
  logic [DATA_W-1:0] mem_data;
  logic              alu_valid;
  logic              alu_ready;
  logic [4:0]        alu_reg;
  logic [DATA_W-1:0] alu_data;
  logic              wb_stall;
  logic [4:0]        WriteRegister;
  logic [DATA_W-1:0] WriteData;
  logic              RegWrite;
  logic [4:0]        rd_reg1;
  logic [4:0]        rd_reg2;
  logic              fwd_hit1;
  logic              fwd_hit2;
  logic [DATA_W-1:0] fwd_data1;
  logic [DATA_W-1:0] fwd_data2;
  logic [2:0]        count;
  logic              empty;
  logic              full;

  modport slave (
    input  mem_valid, mem_reg, mem_data, alu_valid, alu_reg, alu_data,
           wb_stall, rd_reg1, rd_reg2,
    output mem_ready, alu_ready, WriteRegister, WriteData, RegWrite,
           fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, count, empty, full
  );

  modport master (
    output mem_valid, mem_reg, mem_data, alu_valid, alu_reg, alu_data,
           wb_stall, rd_reg1, rd_reg2,
    input  mem_ready, alu_ready, WriteRegister, WriteData, RegWrite,
           fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, count, empty, full
  );
endinterface

// File: rtl/regfile_writeback.sv
// Writeback arbiter: 4-entry queue merging load and ALU results into a single
// register-file write port, with youngest-match bypass over pending entries.
module regfile_writeback #(
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  regfile_writeback_if.slave  bus
);

  localparam logic [4:0] XZR = 5'd31;

  typedef struct packed {
    logic [4:0]        r;
    logic [DATA_W-1:0] d;
  } entry_t;

  logic [1:0] head_q, head_d;
  logic [1:0] tail_q, tail_d;
  logic [2:0] count_q, count_d;
  entry_t     ent_q [4];
  entry_t     ent_d [4];

  logic   full_w, empty_w;
  logic   mem_fire, alu_fire, enq, pop;
  entry_t push_ent;

  // Readiness depends only on the registered count, never on this cycle's pop.
  assign empty_w  = (count_q == 3'd0);
  assign full_w   = (count_q == 3'd4);
  assign mem_fire = bus.mem_valid && !full_w;
  assign alu_fire = bus.alu_valid && !full_w && !bus.mem_valid;
  assign pop      = !empty_w && !bus.wb_stall;

  always_comb begin
    push_ent = mem_fire ? entry_t'({bus.mem_reg, bus.mem_data})
                        : entry_t'({bus.alu_reg, bus.alu_data});
    enq      = (mem_fire || alu_fire) && (push_ent.r != XZR);
  end

  always_comb begin
    head_d  = head_q + 2'(pop);
    tail_d  = tail_q + 2'(enq);
    count_d = count_q + 3'(enq) - 3'(pop);
    ent_d   = ent_q;
    if (enq) ent_d[tail_q] = push_ent;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= 2'd0;
      tail_q  <= 2'd0;
      count_q <= 3'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage carries no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

  assign bus.mem_ready     = !full_w;
  assign bus.alu_ready     = !full_w && !bus.mem_valid;
  assign bus.RegWrite      = pop;
  assign bus.WriteRegister = empty_w ? 5'd0 : ent_q[head_q].r;
  assign bus.WriteData     = empty_w ? '0 : ent_q[head_q].d;
  assign bus.count         = count_q;
  assign bus.empty         = empty_w;
  assign bus.full          = full_w;

  // Scan oldest to youngest so the last match wins.
  logic [1:0] idx;
  always_comb begin
    idx           = 2'd0;
    bus.fwd_hit1  = 1'b0;
    bus.fwd_hit2  = 1'b0;
    bus.fwd_data1 = '0;
    bus.fwd_data2 = '0;
    for (int i = 0; i < 4; i++) begin
      idx = head_q + 2'(i);
      if (3'(i) < count_q) begin
        if (bus.rd_reg1 != XZR && ent_q[idx].r == bus.rd_reg1) begin
          bus.fwd_hit1  = 1'b1;
          bus.fwd_data1 = ent_q[idx].d;
        end
        if (bus.rd_reg2 != XZR && ent_q[idx].r == bus.rd_reg2) begin
          bus.fwd_hit2  = 1'b1;
          bus.fwd_data2 = ent_q[idx].d;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed steps plus a short random phase,
// checked every cycle against a queue model of the writeback FIFO.
module tb_regfile_writeback;

  logic clk = 1'b0;
  logic rst = 1'b1;

  regfile_writeback_if #(.DATA_W(64)) bus ();

  regfile_writeback #(.DATA_W(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  r;
    logic [63:0] d;
  } ent_t;

  ent_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [64:0] fwd_model(input logic [4:0] rd);
    logic [64:0] res;
    res = '0;
    foreach (sb[i]) if (rd != 5'd31 && sb[i].r == rd) res = {1'b1, sb[i].d};
    return res;
  endfunction

  // Per-cycle model check: sample mid-cycle, retire the head write, then
  // record whichever request the model says is accepted at the coming edge.
  int          m_cnt;
  logic        m_mr, m_ar, m_rw;
  logic [64:0] m_f1, m_f2;
  ent_t        m_push;
  logic        m_pushing;

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      m_cnt = sb.size();
      m_mr  = (m_cnt != 4);
      m_ar  = m_mr && !bus.mem_valid;
      m_rw  = (m_cnt != 0) && !bus.wb_stall;
      m_f1  = fwd_model(bus.rd_reg1);
      m_f2  = fwd_model(bus.rd_reg2);
      chk("count",     64'(bus.count),     64'(m_cnt));
      chk("empty",     64'(bus.empty),     64'(m_cnt == 0));
      chk("full",      64'(bus.full),      64'(m_cnt == 4));
      chk("mem_ready", 64'(bus.mem_ready), 64'(m_mr));
      chk("alu_ready", 64'(bus.alu_ready), 64'(m_ar));
      chk("RegWrite",  64'(bus.RegWrite),  64'(m_rw));
      if (m_cnt != 0) begin
        chk("WriteRegister", 64'(bus.WriteRegister), 64'(sb[0].r));
        chk("WriteData",     bus.WriteData,          sb[0].d);
      end else begin
        chk("WriteRegister", 64'(bus.WriteRegister), 64'd0);
        chk("WriteData",     bus.WriteData,          64'd0);
      end
      chk("fwd_hit1",  64'(bus.fwd_hit1), 64'(m_f1[64]));
      chk("fwd_data1", bus.fwd_data1,     m_f1[63:0]);
      chk("fwd_hit2",  64'(bus.fwd_hit2), 64'(m_f2[64]));
      chk("fwd_data2", bus.fwd_data2,     m_f2[63:0]);
      if (m_rw) void'(sb.pop_front());
      m_pushing = 1'b0;
      m_push    = '0;
      if (bus.mem_valid && m_mr) begin
        m_pushing = 1'b1;
        m_push    = {bus.mem_reg, bus.mem_data};
      end else if (bus.alu_valid && m_ar) begin
        m_pushing = 1'b1;
        m_push    = {bus.alu_reg, bus.alu_data};
      end
      if (m_pushing && m_push.r != 5'd31) sb.push_back(m_push);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic alu_req(input logic [4:0] r, input logic [63:0] d);
    bus.alu_valid = 1'b1;
    bus.alu_reg   = r;
    bus.alu_data  = d;
    cyc();
    bus.alu_valid = 1'b0;
  endtask

  initial begin
    bus.mem_valid = 1'b0; bus.mem_reg = '0; bus.mem_data = '0;
    bus.alu_valid = 1'b0; bus.alu_reg = '0; bus.alu_data = '0;
    bus.wb_stall  = 1'b0; bus.rd_reg1 = 5'd0; bus.rd_reg2 = 5'd0;

    // Reset held for several edges; outputs checked while still in reset.
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rst_empty",     64'(bus.empty),     64'd1);
    chk("rst_full",      64'(bus.full),      64'd0);
    chk("rst_count",     64'(bus.count),     64'd0);
    chk("rst_RegWrite",  64'(bus.RegWrite),  64'd0);
    chk("rst_mem_ready", 64'(bus.mem_ready), 64'd1);
    chk("rst_alu_ready", 64'(bus.alu_ready), 64'd1);
    cyc();
    rst = 1'b0;
    idle(2);

    // Single ALU write: visible on the write port the cycle after acceptance.
    alu_req(5'd5, 64'hA5);
    @(negedge clk);
    chk("single_rw",  64'(bus.RegWrite),      64'd1);
    chk("single_reg", 64'(bus.WriteRegister), 64'd5);
    chk("single_dat", bus.WriteData,          64'hA5);
    cyc();
    @(negedge clk);
    chk("single_rw_after", 64'(bus.RegWrite), 64'd0);
    chk("single_empty",    64'(bus.empty),    64'd1);
    cyc();

    // Load beats ALU in the same cycle; ALU lands the next cycle.
    bus.mem_valid = 1'b1; bus.mem_reg = 5'd3; bus.mem_data = 64'h11;
    bus.alu_valid = 1'b1; bus.alu_reg = 5'd4; bus.alu_data = 64'h22;
    @(negedge clk);
    chk("prio_alu_ready", 64'(bus.alu_ready), 64'd0);
    cyc();
    bus.mem_valid = 1'b0;
    cyc();
    bus.alu_valid = 1'b0;
    idle(4);

    // Fill under stall, fifth push blocked until the first pop.
    bus.wb_stall = 1'b1;
    for (int i = 1; i <= 4; i++) alu_req(5'(i), 64'(i) * 64'h101);
    bus.alu_valid = 1'b1; bus.alu_reg = 5'd5; bus.alu_data = 64'h505;
    @(negedge clk);
    chk("fill_full",      64'(bus.full),      64'd1);
    chk("fill_alu_ready", 64'(bus.alu_ready), 64'd0);
    cyc();
    bus.wb_stall = 1'b0;
    cyc();
    cyc();
    bus.alu_valid = 1'b0;
    idle(6);

    // Bypass picks the youngest of two pending writes to the same register.
    bus.wb_stall = 1'b1;
    alu_req(5'd7, 64'h1);
    alu_req(5'd7, 64'h2);
    bus.rd_reg1 = 5'd7; bus.rd_reg2 = 5'd31;
    @(negedge clk);
    chk("byp_hit1",  64'(bus.fwd_hit1), 64'd1);
    chk("byp_data1", bus.fwd_data1,     64'h2);
    chk("byp_hit2",  64'(bus.fwd_hit2), 64'd0);
    chk("byp_data2", bus.fwd_data2,     64'd0);
    cyc();
    bus.wb_stall = 1'b0;
    idle(4);
    bus.rd_reg1 = 5'd0; bus.rd_reg2 = 5'd0;

    // Writes to the zero register complete but never enqueue.
    alu_req(5'd31, 64'hFFFF);
    @(negedge clk);
    chk("xzr_count", 64'(bus.count),    64'd0);
    chk("xzr_rw",    64'(bus.RegWrite), 64'd0);
    cyc();

    // Reset with a stalled queue; a handshake on the reset edge is dropped.
    bus.wb_stall = 1'b1;
    alu_req(5'd10, 64'hA);
    alu_req(5'd11, 64'hB);
    alu_req(5'd12, 64'hC);
    rst = 1'b1;
    bus.mem_valid = 1'b1; bus.mem_reg = 5'd13; bus.mem_data = 64'hD;
    cyc();
    rst = 1'b0;
    bus.mem_valid = 1'b0;
    @(negedge clk);
    chk("rstq_count", 64'(bus.count),    64'd0);
    chk("rstq_empty", 64'(bus.empty),    64'd1);
    chk("rstq_rw",    64'(bus.RegWrite), 64'd0);
    cyc();
    bus.wb_stall = 1'b0;
    idle(4);

    // Random traffic with occasional stalls and zero-register requests.
    for (int n = 0; n < 200; n++) begin
      bus.mem_valid = ($urandom_range(0, 2) == 0);
      bus.mem_reg   = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      bus.mem_data  = {$urandom, $urandom};
      bus.alu_valid = ($urandom_range(0, 1) == 0);
      bus.alu_reg   = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      bus.alu_data  = {$urandom, $urandom};
      bus.wb_stall  = ($urandom_range(0, 3) == 0);
      bus.rd_reg1   = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      bus.rd_reg2   = 5'($urandom_range(0, 7));
      cyc();
    end
    bus.mem_valid = 1'b0;
    bus.alu_valid = 1'b0;
    bus.wb_stall  = 1'b0;
    idle(8);
    @(negedge clk);
    chk("final_empty", 64'(bus.empty), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_writeback.md
REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; both ports are listed below.
REQ-002 The block SHALL have these ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- mem_valid  in  1  load-unit writeback request.
- mem_ready  out  1  load-unit request accepted.
- mem_reg  in  5  load destination register.
- mem_data  in  64  load result.
- alu_valid  in  1  ALU writeback request.
- alu_ready  out  1  ALU request accepted.
- alu_reg  in  5  ALU destination register.
- alu_data  in  64  ALU result.
- wb_stall  in  1  holds the register-file write port; no drain this cycle.
- WriteRegister  out  5  register-file write address.
- WriteData  out  64  register-file write data.
- RegWrite  out  1  register-file write enable.
- rd_reg1  in  5  bypass lookup address, port 1.
- rd_reg2  in  5  bypass lookup address, port 2.
- fwd_hit1  out  1  pending write to rd_reg1 exists.
- fwd_hit2  out  1  pending write to rd_reg2 exists.
- fwd_data1  out  64  youngest pending data for rd_reg1.
- fwd_data2  out  64  youngest pending data for rd_reg2.
- count  out  3  queued entries, 0..4.
- empty  out  1  count==0.
- full  out  1  count==4.

Function
REQ-003 Queue: 4-entry FIFO of {reg[4:0], data[63:0]}; 2-bit head/tail pointers wrap 3->0; 3-bit count.
REQ-004 Handshake: a transfer occurs at a rising edge when valid && ready are both high; payload is sampled on that edge.
REQ-005 Readiness: mem_ready = !full; alu_ready = !full && !mem_valid; at most one push per cycle; load unit has fixed priority.
REQ-006 Full gating: when full, both readies are low, including in a cycle where a pop occurs; ready has no combinational path from pop.
REQ-007 Zero register: an accepted request with reg==31 completes the handshake, is not enqueued, and leaves count unchanged.
REQ-008 Drain: when !empty && !wb_stall, RegWrite=1, WriteRegister=head.reg, WriteData=head.data; head pops at that edge.
REQ-009 Idle outputs: when empty || wb_stall, RegWrite=0; WriteRegister and WriteData are 0 when empty and hold the head entry when stalled.
REQ-010 Latency: a request accepted at edge N into an empty queue with wb_stall low SHALL drive RegWrite=1 during cycle N..N+1; the register file captures it at edge N+1.
REQ-011 Simultaneous push and pop: count is unchanged, both pointers advance, and the new entry lands behind any remaining entries.
REQ-012 Order: entries are written in acceptance order; no coalescing of entries with the same register.
REQ-013 Bypass: fwd_hitK=1 when rd_regK!=31 and any valid queue entry has reg==rd_regK; fwd_dataK is the youngest matching entry, else 0. Lookup is combinational from queue state and includes the head being written this cycle.
REQ-014 Bypass exclusion: the bypass SHALL NOT see requests not yet accepted at the current edge.
REQ-015 Outputs: empty, full and count are derived from the registered count only.

Reset
REQ-016 When rst is high at an edge, count, head and tail SHALL reset to 0 and all queued entries are discarded, including mid-drain or mid-stall.
REQ-017 During and after reset, RegWrite, WriteRegister, WriteData, fwd_hit1/2 and fwd_data1/2 SHALL be 0, empty=1 and full=0; mem_ready=1 and alu_ready=!mem_valid.
REQ-018 A handshake coinciding with the reset edge SHALL be dropped.

Verification
REQ-019 Single write: alu {reg 5, 0xA5} at edge N, no stall -> cycle N+1 has RegWrite=1, WriteRegister=5, WriteData=0xA5; next cycle RegWrite=0, empty=1.
REQ-020 Priority: mem {3, 0x11} and alu {4, 0x22} in the same cycle -> mem accepted and alu_ready=0; alu accepted the next cycle; writes drain in order reg 3 then reg 4.
REQ-021 Fill and stall: wb_stall=1 with 5 ALU pushes to regs 1..5 -> 4 accepted, full=1, alu_ready=0; release stall -> regs 1,2,3,4 drain on consecutive cycles with pointer wrap; the 5th push is accepted after the first pop.
REQ-022 Bypass: with stall, queue {7, 0x1}, {7, 0x2}, rd_reg1=7, rd_reg2=31 -> fwd_hit1=1, fwd_data1=0x2, fwd_hit2=0, fwd_data2=0.
REQ-023 XZR: alu {31, 0xFFFF} accepted -> count stays 0, RegWrite never asserts.
REQ-024 Reset mid-operation: queue 3 entries under stall, pulse rst -> next cycle count=0, empty=1, RegWrite=0, no discarded entry is ever written.
